// File: rtl/accum_sched.sv
`default_nettype none
// ============================================================================
// Module   : accum_sched
// Purpose  : Turns the DPE result stream into accumulator commands, stalling
//            on read-after-write hazards and on missing output FIFO credits.
// Revision : 1.0 - initial release
// ============================================================================
module accum_sched #(
   parameter int DATAW       = 32,
   parameter int DEPTH       = 512,
   parameter int ADDRW       = $clog2(DEPTH),
   parameter int CHUNKW      = 8,
   parameter int VECW        = 16,
   parameter int HAZARD_GAP  = 4,
   parameter int OUT_CREDITS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ADDRW-1:0]  cfg_rows,
   input  logic [CHUNKW-1:0] cfg_chunks,
   input  logic [VECW-1:0]   cfg_vectors,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATAW-1:0]  s_data,
   output logic              acc_valid,
   output logic [DATAW-1:0]  acc_data,
   output logic [ADDRW-1:0]  acc_addr,
   output logic              acc_accum,
   output logic              acc_last,
   input  logic              credit_ret,
   output logic              busy,
   output logic              done
);

   localparam int c_credw = $clog2(OUT_CREDITS + 1);
   localparam int c_win   = (HAZARD_GAP > 1) ? HAZARD_GAP - 1 : 1;
   localparam logic [c_credw-1:0] c_credits_max = c_credw'(OUT_CREDITS);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [ADDRW-1:0]   r_rows;
   logic [ADDRW-1:0]   r_row;
   logic [CHUNKW-1:0]  r_chunks;
   logic [CHUNKW-1:0]  r_chunk;
   logic [VECW-1:0]    r_vectors;
   logic [VECW-1:0]    r_vector;
   logic [c_credw-1:0] r_credits;

   logic               r_acc_valid;
   logic [DATAW-1:0]   r_acc_data;
   logic [ADDRW-1:0]   r_acc_addr;
   logic               r_acc_accum;
   logic               r_acc_last;
   logic               r_done;

   logic w_cfg_accept;
   logic w_accept;
   logic w_row_wrap;
   logic w_chunk_wrap;
   logic w_final;
   logic w_accum_next;
   logic w_last_next;
   logic w_hit;
   logic w_haz;
   logic w_cred_dec;
   logic w_cred_inc;

   assign w_row_wrap   = (r_row == r_rows);
   assign w_chunk_wrap = (r_chunk == r_chunks);
   assign w_final      = w_row_wrap && w_chunk_wrap && (r_vector == r_vectors);
   assign w_accum_next = (r_chunk != '0);
   assign w_last_next  = w_chunk_wrap;
   assign w_haz        = w_accum_next && w_hit;
   assign w_accept     = s_valid && s_ready;

   // ------------------------------------------------------------------------
   // Control FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      cfg_ready    = 1'b0;
      busy         = 1'b0;
      s_ready      = 1'b0;
      w_cfg_accept = 1'b0;
      case (r_state)
         ST_IDLE: begin
            cfg_ready    = 1'b1;
            w_cfg_accept = cfg_valid;
            if (cfg_valid) begin
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            busy    = 1'b1;
            // Built from registered state only so it never loops through s_valid
            s_ready = !w_haz && !(w_last_next && (r_credits == '0));
            if (s_valid && s_ready && w_final) begin
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Row / chunk / vector counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rows    <= '0;
         r_chunks  <= '0;
         r_vectors <= '0;
         r_row     <= '0;
         r_chunk   <= '0;
         r_vector  <= '0;
      end else if (w_cfg_accept) begin
         r_rows    <= cfg_rows;
         r_chunks  <= cfg_chunks;
         r_vectors <= cfg_vectors;
         r_row     <= '0;
         r_chunk   <= '0;
         r_vector  <= '0;
      end else if (w_accept) begin
         if (w_row_wrap) begin
            r_row <= '0;
            if (w_chunk_wrap) begin
               r_chunk  <= '0;
               r_vector <= r_vector + 1'b1;
            end else begin
               r_chunk <= r_chunk + 1'b1;
            end
         end else begin
            r_row <= r_row + 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Hazard window: every issue slot is recorded, bubbles shift in as invalid
   // ------------------------------------------------------------------------
   generate
      if (HAZARD_GAP > 1) begin : g_window
         logic [c_win-1:0] r_win_vld;
         logic [ADDRW-1:0] r_win_addr [c_win];

         always_ff @(posedge clk) begin
            if (rst) begin
               r_win_vld <= '0;
               for (int i = 0; i < c_win; i++) begin
                  r_win_addr[i] <= '0;
               end
            end else begin
               r_win_vld[0]  <= w_accept;
               r_win_addr[0] <= r_row;
               for (int i = 1; i < c_win; i++) begin
                  r_win_vld[i]  <= r_win_vld[i-1];
                  r_win_addr[i] <= r_win_addr[i-1];
               end
            end
         end

         always_comb begin
            w_hit = 1'b0;
            for (int i = 0; i < c_win; i++) begin
               if (r_win_vld[i] && (r_win_addr[i] == r_row)) begin
                  w_hit = 1'b1;
               end
            end
         end
      end else begin : g_no_window
         assign w_hit = 1'b0;
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Output FIFO credits; a return that coincides with a consume cancels it
   // ------------------------------------------------------------------------
   assign w_cred_dec = w_accept && w_last_next;
   assign w_cred_inc = credit_ret && (r_credits != c_credits_max);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_credits <= c_credits_max;
      end else if (w_cred_dec && !credit_ret) begin
         r_credits <= r_credits - 1'b1;
      end else if (w_cred_inc && !w_cred_dec) begin
         r_credits <= r_credits + 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Registered accumulator command
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_acc_valid <= 1'b0;
         r_acc_data  <= '0;
         r_acc_addr  <= '0;
         r_acc_accum <= 1'b0;
         r_acc_last  <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_acc_valid <= w_accept;
         r_done      <= w_accept && w_final;
         if (w_accept) begin
            r_acc_data  <= s_data;
            r_acc_addr  <= r_row;
            r_acc_accum <= w_accum_next;
            r_acc_last  <= w_last_next;
         end
      end
   end

   assign acc_valid = r_acc_valid;
   assign acc_data  = r_acc_data;
   assign acc_addr  = r_acc_addr;
   assign acc_accum = r_acc_accum;
   assign acc_last  = r_acc_last;
   assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_accum_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_accum_sched
// Purpose  : Scoreboard bench for accum_sched with directed job vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_accum_sched;

   localparam int DATAW  = 32;
   localparam int ADDRW  = 9;
   localparam int CHUNKW = 8;
   localparam int VECW   = 16;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_valid;
   logic              cfg_ready;
   logic [ADDRW-1:0]  cfg_rows;
   logic [CHUNKW-1:0] cfg_chunks;
   logic [VECW-1:0]   cfg_vectors;
   logic              s_valid;
   logic              s_ready;
   logic [DATAW-1:0]  s_data;
   logic              acc_valid;
   logic [DATAW-1:0]  acc_data;
   logic [ADDRW-1:0]  acc_addr;
   logic              acc_accum;
   logic              acc_last;
   logic              credit_ret;
   logic              busy;
   logic              done;

   accum_sched #(
      .DATAW(DATAW), .DEPTH(512), .ADDRW(ADDRW), .CHUNKW(CHUNKW),
      .VECW(VECW), .HAZARD_GAP(4), .OUT_CREDITS(2)
   ) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_rows(cfg_rows), .cfg_chunks(cfg_chunks), .cfg_vectors(cfg_vectors),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .acc_valid(acc_valid), .acc_data(acc_data), .acc_addr(acc_addr),
      .acc_accum(acc_accum), .acc_last(acc_last),
      .credit_ret(credit_ret), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [DATAW-1:0] data;
      logic [ADDRW-1:0] addr;
      logic             accum;
      logic             last;
      logic             done;
      int               gap;
   } exp_t;

   exp_t        exp_q[$];
   int          gap_tab[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          last_cyc = 0;
   int          feed_left = 0;
   logic [31:0] feed_data = 0;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Feeder: offers consecutive data words, advances on each accepted beat
   initial begin
      s_valid = 1'b0;
      s_data  = '0;
      forever begin
         @(negedge clk);
         if (feed_left > 0) begin
            s_valid = 1'b1;
            s_data  = feed_data;
            if (s_ready) begin
               feed_left--;
               feed_data++;
            end
         end else begin
            s_valid = 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard for every accumulator command
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (acc_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(acc_addr), 64'h1ff_ffff);
            end else begin
               e = exp_q.pop_front();
               chk("beat{data,addr,accum,last,done}",
                   {20'h0, acc_data, acc_addr, acc_accum, acc_last, done},
                   {20'h0, e.data, e.addr, e.accum, e.last, e.done});
               if (e.gap != 0) chk("beat_gap", 64'(cyc - last_cyc), 64'(e.gap));
               if (e.done) begin
                  chk("cfg_ready_at_done", 64'(cfg_ready), 64'd1);
                  chk("busy_at_done", 64'(busy), 64'd0);
               end
            end
            last_cyc = cyc;
         end
      end
   end

   // Pushes the hand-derivable beat sequence, issues the config, starts feeding
   task automatic start_job(input int rows, input int chunks, input int vectors,
                            input int def_gap, input int n_exp, input logic [31:0] base);
      int   total;
      int   r;
      int   c;
      int   t;
      exp_t e;
      total = (rows + 1) * (chunks + 1) * (vectors + 1);
      for (int k = 0; k < total; k++) begin
         if (n_exp >= 0 && k >= n_exp) break;
         r       = k % (rows + 1);
         c       = (k / (rows + 1)) % (chunks + 1);
         e.data  = base + 32'(k);
         e.addr  = ADDRW'(r);
         e.accum = (c != 0);
         e.last  = (c == chunks);
         e.done  = (k == total - 1);
         e.gap   = (k < gap_tab.size()) ? gap_tab[k] : ((k == 0) ? 0 : def_gap);
         exp_q.push_back(e);
      end
      gap_tab.delete();
      t = 0;
      @(negedge clk);
      while (!cfg_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("cfg_ready_before_job", 64'(cfg_ready), 64'd1);
      cfg_valid   = 1'b1;
      cfg_rows    = ADDRW'(rows);
      cfg_chunks  = CHUNKW'(chunks);
      cfg_vectors = VECW'(vectors);
      feed_data   = base;
      feed_left   = total;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk("busy_in_run", 64'(busy), 64'd1);
      chk("cfg_ready_in_run", 64'(cfg_ready), 64'd0);
   endtask

   task automatic wait_drain(input string name);
      int t;
      t = 0;
      while ((exp_q.size() != 0 || feed_left != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk(name, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      feed_left = 0;
   endtask

   initial begin
      int t;
      rst         = 1'b1;
      cfg_valid   = 1'b0;
      cfg_rows    = '0;
      cfg_chunks  = '0;
      cfg_vectors = '0;
      credit_ret  = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("rst_outputs{valid,busy,done,s_ready,accum,last}",
          {acc_valid, busy, done, s_ready, acc_accum, acc_last}, 64'd0);
      chk("rst_acc_data_addr", {acc_data, acc_addr}, 64'd0);
      rst        = 1'b0;
      credit_ret = 1'b1;

      // T1: 12 back-to-back beats
      start_job(3, 2, 0, 1, -1, 32'h1000);
      wait_drain("t1_drain");

      // T6: config strobes during RUN must be ignored
      start_job(3, 2, 0, 1, -1, 32'h2000);
      repeat (2) @(negedge clk);
      cfg_valid   = 1'b1;
      cfg_rows    = 9'd1;
      cfg_chunks  = 8'd0;
      cfg_vectors = 16'd5;
      @(negedge clk);
      cfg_valid = 1'b0;
      @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_chunks = 8'd7;
      @(negedge clk);
      cfg_valid = 1'b0;
      wait_drain("t6_drain");

      // T2: single row, hazard bubbles of three cycles
      gap_tab = '{0, 4, 4};
      start_job(0, 2, 0, 0, -1, 32'h3000);
      wait_drain("t2_drain");

      // Two vectors: chunk-1 row 0 waits for the row-0 overwrite to age out
      gap_tab = '{0, 1, 3, 1, 1, 1, 3, 1};
      start_job(1, 1, 1, 0, -1, 32'h4000);
      wait_drain("vec_drain");

      // T3: two credits, then one beat per returned credit
      @(negedge clk);
      credit_ret = 1'b0;
      gap_tab = '{0, 1};
      start_job(3, 0, 0, 0, -1, 32'h5000);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("t3_stall_no_credit", 64'(s_ready), 64'd0);
         @(negedge clk);
      end
      chk("t3_beats_left_a", 64'(feed_left), 64'd2);
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk("t3_stall_again", 64'(s_ready), 64'd0);
         @(negedge clk);
      end
      chk("t3_beats_left_b", 64'(feed_left), 64'd1);
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      wait_drain("t3_drain");

      // T4: credit return coinciding with a consume keeps credits at 1
      @(negedge clk);
      credit_ret = 1'b1;
      @(negedge clk);
      credit_ret = 1'b0;
      start_job(1, 0, 0, 1, -1, 32'h6000);
      credit_ret = 1'b1;
      chk("t4_ready_first", 64'(s_ready), 64'd1);
      @(negedge clk);
      credit_ret = 1'b0;
      chk("t4_ready_second", 64'(s_ready), 64'd1);
      wait_drain("t4_drain");

      // T5: reset after five accepted beats, then a fresh job
      credit_ret = 1'b1;
      start_job(3, 2, 0, 1, 5, 32'h7000);
      t = 0;
      while (feed_left != 7 && t < 100) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("t5_reached_beat5", 64'(feed_left), 64'd7);
      @(posedge clk);
      #1;
      rst       = 1'b1;
      feed_left = 0;
      @(negedge clk);
      @(negedge clk);
      chk("t5_acc_valid", 64'(acc_valid), 64'd0);
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_cfg_ready", 64'(cfg_ready), 64'd1);
      chk("t5_scoreboard_empty", 64'(exp_q.size()), 64'd0);
      rst = 1'b0;
      start_job(3, 2, 0, 1, -1, 32'h8000);
      wait_drain("t5_restart_drain");

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
